// File: rtl/pico_cyc10_seg_pkg.sv
// rtl/pico_cyc10_seg_pkg.sv - shared constants and helpers for the segment scanner
package pico_cyc10_seg_pkg;

    // Bit positions within the 8-bit segment bus {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g..a} pattern for each hex nibble 0..F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Index width for a counter of n states, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pico_cyc10_seg_hexdec.sv
// rtl/pico_cyc10_seg_hexdec.sv - nibble to active-high seven-segment pattern
module pico_cyc10_seg_hexdec
    import pico_cyc10_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_pat
);

    // Pure table lookup; polarity is handled by the caller
    always_comb begin
        seg_pat = HEX_SEG[nibble];
    end

endmodule

// File: rtl/pico_cyc10_seg_scan.sv
// rtl/pico_cyc10_seg_scan.sv - time-multiplexed seven-segment display scanner
module pico_cyc10_seg_scan
    import pico_cyc10_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    frame_start
);

    localparam int CW = idx_width(CLK_DIV);
    localparam int IW = idx_width(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    // XOR masks turning active-high patterns into pin polarity; also the idle value
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   snap_data_q, snap_data_d;
    logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     dig_q, dig_d;
    logic                      frame_start_q, frame_start_d;

    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic [NUM_DIGITS-1:0]     dig_onehot;
    logic [6:0]                hex_pat;

    // Select the snapshot nibble, decimal point and digit strobe for the current slot
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        dig_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib       = snap_data_q[4*k +: 4];
                cur_dp        = snap_dp_q[k];
                dig_onehot[k] = 1'b1;
            end
        end
    end

    pico_cyc10_seg_hexdec u_hexdec (
        .nibble  (cur_nib),
        .seg_pat (hex_pat)
    );

    // Prescaler, digit index, frame snapshot and output decode from pre-edge state
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_data_d   = snap_data_q;
        snap_dp_d     = snap_dp_q;
        seg_d         = SEG_OFF;
        dig_d         = DIG_OFF;
        frame_start_d = 1'b0;

        if (en) begin
            if (cnt_q == '0 && idx_q == '0) begin
                snap_data_d   = data_in;
                snap_dp_d     = dp_in;
                frame_start_d = 1'b1;
            end

            // Blank window at the head of each slot keeps dig and seg off together
            if (cnt_q >= CNT_BLANK) begin
                seg_d = {cur_dp, hex_pat} ^ SEG_OFF;
                dig_d = dig_onehot ^ DIG_OFF;
            end

            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Disabled: park at the frame start so re-enable behaves like reset release
            cnt_d = '0;
            idx_d = '0;
        end
    end

    // State and output registers; reset forces the display dark immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_data_q   <= '0;
            snap_dp_q     <= '0;
            seg_q         <= SEG_OFF;
            dig_q         <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_data_q   <= snap_data_d;
            snap_dp_q     <= snap_dp_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dig         = dig_q;
    assign frame_start = frame_start_q;

endmodule
